// File: rtl/axi_read_master_if.sv
// AXI4 read-channel bundle (AR + R) shared by the read initiator and its responder.
// The master modport drives AR and RREADY; the slave modport drives R and ARREADY.
interface axi_read_master_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64,
   parameter int ID_W   = 4
);
   logic [ADDR_W-1:0] araddr;
   logic [7:0]        arlen;
   logic [2:0]        arsize;
   logic [1:0]        arburst;
   logic [ID_W-1:0]   arid;
   logic              arvalid;
   logic              arready;

   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rlast;
   logic [ID_W-1:0]   rid;
   logic              rvalid;
   logic              rready;

   modport master (
      output araddr, arlen, arsize, arburst, arid, arvalid,
      input  arready,
      input  rdata, rresp, rlast, rid, rvalid,
      output rready
   );

   modport slave (
      input  araddr, arlen, arsize, arburst, arid, arvalid,
      output arready,
      output rdata, rresp, rlast, rid, rvalid,
      input  rready
   );
endinterface

// File: rtl/axi_read_master.sv
// Single-outstanding AXI4 read initiator: one request -> one INCR AR burst, R beats passed
// straight to the client with per-beat error checks. Optional watchdog: AXI_RD_TIMEOUT_EN.
module axi_read_master #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 64,
   parameter int ID_W    = 4,
   parameter int AXI_ID  = 0,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rstn,

   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [7:0]        req_len,
   input  logic [2:0]        req_size,

   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_last,
   output logic              rsp_err,

   output logic              busy,
   output logic              err_sticky,
   output logic              timeout,

   axi_read_master_if.master axi
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADDR,
      S_DATA
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        len_q, len_d;
   logic [2:0]        size_q, size_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              err_q, err_d;

   logic              ar_hs;
   logic              r_hs;
   logic              beat_err;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         len_q   <= '0;
         size_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         size_q  <= size_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // A beat is wrong if the responder flags it, answers for another ID, or places RLAST
   // anywhere other than the beat whose index equals the requested ARLEN.
   assign beat_err = (axi.rresp != 2'b00)
                  || (axi.rid != ID_W'(AXI_ID))
                  || (axi.rlast != (cnt_q == len_q));

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      len_d       = len_q;
      size_d      = size_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      req_ready   = 1'b0;
      rsp_valid   = 1'b0;
      rsp_last    = 1'b0;
      rsp_err     = 1'b0;
      axi.arvalid = 1'b0;
      axi.rready  = 1'b0;
      ar_hs       = 1'b0;
      r_hs        = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               addr_d  = req_addr;
               len_d   = req_len;
               size_d  = req_size;
               err_d   = 1'b0;
               state_d = S_ADDR;
            end
         end

         S_ADDR: begin
            axi.arvalid = 1'b1;
            ar_hs       = axi.arready;
            if (ar_hs) begin
               cnt_d   = '0;
               state_d = S_DATA;
            end
         end

         S_DATA: begin
            rsp_valid  = axi.rvalid;
            rsp_last   = axi.rlast;
            rsp_err    = axi.rvalid && beat_err;
            axi.rready = rsp_ready;
            r_hs       = axi.rvalid && rsp_ready;
            if (r_hs) begin
               // Saturate so a responder that never sends RLAST cannot alias beat 0.
               if (cnt_q != 8'hFF) begin
                  cnt_d = cnt_q + 8'd1;
               end
               if (beat_err) begin
                  err_d = 1'b1;
               end
               if (axi.rlast) begin
                  state_d = S_IDLE;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign axi.araddr  = addr_q;
   assign axi.arlen   = len_q;
   assign axi.arsize  = size_q;
   assign axi.arburst = 2'b01;
   assign axi.arid    = ID_W'(AXI_ID);

   assign rsp_data = axi.rdata;
   assign busy     = (state_q != S_IDLE);

`ifdef AXI_RD_TIMEOUT_EN
   logic [31:0] wd_q, wd_d;
   logic        tmo_q, tmo_d;

   // Counts consecutive stalled cycles while a burst is open; only observes, never aborts.
   always_comb begin
      wd_d  = wd_q;
      tmo_d = tmo_q;
      if ((state_q == S_IDLE) || ar_hs || r_hs) begin
         wd_d = '0;
      end else if (wd_q != 32'(TIMEOUT)) begin
         wd_d = wd_q + 32'd1;
      end
      if (wd_d == 32'(TIMEOUT)) begin
         tmo_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wd_q  <= '0;
         tmo_q <= 1'b0;
      end else begin
         wd_q  <= wd_d;
         tmo_q <= tmo_d;
      end
   end

   assign timeout    = tmo_q;
   assign err_sticky = err_q | tmo_q;
`else
   logic [31:0] unused_timeout;
   logic        unused_hs;

   assign unused_timeout = 32'(TIMEOUT);
   assign unused_hs      = ar_hs ^ r_hs;
   assign timeout        = 1'b0;
   assign err_sticky     = err_q;
`endif

endmodule

// File: tb/tb_axi_read_master.sv
// Directed bench for axi_read_master: driver pushes expected AR/R results into queues,
// negedge monitor pops and compares whenever the DUT presents a handshake.
module tb_axi_read_master;

   logic        clk = 1'b0;
   logic        rstn;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [7:0]  req_len;
   logic [2:0]  req_size;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [63:0] rsp_data;
   logic        rsp_last;
   logic        rsp_err;
   logic        busy;
   logic        err_sticky;
   logic        timeout;

   int tests = 0;
   int fails = 0;

   axi_read_master_if #(.ADDR_W(32), .DATA_W(64), .ID_W(4)) axi ();

   axi_read_master #(
      .ADDR_W(32), .DATA_W(64), .ID_W(4), .AXI_ID(0), .TIMEOUT(16)
   ) dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_len(req_len), .req_size(req_size),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_last(rsp_last), .rsp_err(rsp_err),
      .busy(busy), .err_sticky(err_sticky), .timeout(timeout),
      .axi(axi)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] d;
      logic        l;
      logic        e;
   } beat_t;

   typedef struct packed {
      logic [31:0] a;
      logic [7:0]  len;
      logic [2:0]  size;
   } ar_t;

   beat_t exp_q[$];
   ar_t   ar_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares every presented handshake against the queued expectations.
   always @(negedge clk) begin
      beat_t b;
      ar_t   a;
      if (rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            chk("beat_unexpected", 64'd1, 64'd0);
         end else begin
            b = exp_q.pop_front();
            chk("rsp_data", rsp_data, b.d);
            chk("rsp_last", 64'(rsp_last), 64'(b.l));
            chk("rsp_err", 64'(rsp_err), 64'(b.e));
         end
      end
      if (axi.arvalid && axi.arready) begin
         if (ar_q.size() == 0) begin
            chk("ar_unexpected", 64'd1, 64'd0);
         end else begin
            a = ar_q.pop_front();
            chk("araddr", 64'(axi.araddr), 64'(a.a));
            chk("arlen", 64'(axi.arlen), 64'(a.len));
            chk("arsize", 64'(axi.arsize), 64'(a.size));
            chk("arburst", 64'(axi.arburst), 64'd1);
            chk("arid", 64'(axi.arid), 64'd0);
         end
      end
   end

   // One burst. err_beat: beat index answered with RRESP=SLVERR; last_beat: beat carrying
   // RLAST; rst_beat: beat during which reset is asserted instead of a handshake.
   task automatic do_burst(input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [63:0] base,
                           input int ar_wait, input bit toggle, input int err_beat,
                           input int last_beat, input int rst_beat);
      bit   phase = 1'b1;
      bit   done;
      bit   any_err = 1'b0;
      int   guard;
      logic e;

      chk("req_ready_idle", 64'(req_ready), 64'd1);
      req_valid = 1'b1;
      req_addr  = addr;
      req_len   = len;
      req_size  = size;
      ar_q.push_back('{a: addr, len: len, size: size});
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("arvalid_issue", 64'(axi.arvalid), 64'd1);
      chk("err_clr_on_accept", 64'(err_sticky), 64'd0);
      chk("req_ready_busy", 64'(req_ready), 64'd0);

      for (int i = 0; i < ar_wait; i++) begin
         chk("arvalid_hold", 64'(axi.arvalid), 64'd1);
         chk("araddr_hold", 64'(axi.araddr), 64'(addr));
         chk("arlen_hold", 64'(axi.arlen), 64'(len));
         @(posedge clk); #1;
      end
      axi.arready = 1'b1;
      @(posedge clk); #1;
      axi.arready = 1'b0;
      chk("data_state_busy", 64'(busy), 64'd1);
      chk("arvalid_drop", 64'(axi.arvalid), 64'd0);

      for (int b = 0; b <= last_beat; b++) begin
         axi.rvalid = 1'b1;
         axi.rdata  = base + 64'(b);
         axi.rresp  = (b == err_beat) ? 2'b10 : 2'b00;
         axi.rlast  = (b == last_beat);
         axi.rid    = 4'd0;
         if (b == rst_beat) begin
            rsp_ready = 1'b1;
            #1 rstn = 1'b0;
            #1;
            chk("rst_arvalid", 64'(axi.arvalid), 64'd0);
            chk("rst_rready", 64'(axi.rready), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            axi.rvalid = 1'b0;
            rsp_ready  = 1'b0;
            @(posedge clk); #1;
            rstn = 1'b1;
            chk("rst_err_sticky", 64'(err_sticky), 64'd0);
            return;
         end
         e = (b == err_beat) || ((b == last_beat) != (b == int'(len)));
         any_err |= e;
         exp_q.push_back('{d: base + 64'(b), l: (b == last_beat), e: e});
         done  = 1'b0;
         guard = 0;
         while (!done && guard < 20) begin
            rsp_ready = toggle ? phase : 1'b1;
            phase     = !phase;
            @(negedge clk);
            chk("rready_track", 64'(axi.rready), 64'(rsp_ready));
            done = rsp_ready;
            guard++;
            @(posedge clk); #1;
         end
         if (!done) chk("beat_timeout", 64'd1, 64'd0);
      end
      axi.rvalid = 1'b0;
      axi.rlast  = 1'b0;
      rsp_ready  = 1'b0;
      chk("idle_after_burst", 64'(busy), 64'd0);
      chk("req_ready_after", 64'(req_ready), 64'd1);
      chk("err_sticky_after", 64'(err_sticky), 64'(any_err));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn        = 1'b0;
      req_valid   = 1'b0;
      req_addr    = '0;
      req_len     = '0;
      req_size    = '0;
      rsp_ready   = 1'b0;
      axi.arready = 1'b0;
      axi.rvalid  = 1'b0;
      axi.rdata   = '0;
      axi.rresp   = '0;
      axi.rlast   = 1'b0;
      axi.rid     = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy0", 64'(busy), 64'd0);
      chk("rst_arvalid0", 64'(axi.arvalid), 64'd0);
      chk("rst_araddr0", 64'(axi.araddr), 64'd0);
      chk("rst_arlen0", 64'(axi.arlen), 64'd0);
      chk("rst_err0", 64'(err_sticky), 64'd0);
      chk("rst_timeout0", 64'(timeout), 64'd0);
      rstn = 1'b1;
      @(posedge clk); #1;
      chk("idle_req_ready", 64'(req_ready), 64'd1);

      // Stray R and AR-ready traffic in IDLE must be ignored.
      axi.rvalid  = 1'b1;
      axi.arready = 1'b1;
      rsp_ready   = 1'b1;
      #1;
      chk("idle_rready", 64'(axi.rready), 64'd0);
      chk("idle_rsp_valid", 64'(rsp_valid), 64'd0);
      @(posedge clk); #1;
      chk("idle_stays", 64'(busy), 64'd0);
      axi.rvalid  = 1'b0;
      axi.arready = 1'b0;
      rsp_ready   = 1'b0;

      // Single beat.
      do_burst(32'h8000_0000, 8'd0, 3'd3, 64'h1234, 0, 1'b0, -1, 0, -1);
      // Four beats with client back-pressure alternating every cycle.
      do_burst(32'h0000_1000, 8'd3, 3'd3, 64'hA000_0000_0000_0010, 0, 1'b1, -1, 3, -1);
      // AR held off for five cycles.
      do_burst(32'h0000_2040, 8'd1, 3'd2, 64'hB0, 5, 1'b0, -1, 1, -1);
      // SLVERR on beat 2.
      do_burst(32'h0000_3000, 8'd3, 3'd3, 64'hC0, 0, 1'b0, 2, 3, -1);
      // Early RLAST on beat 1; request accept clears the previous sticky error.
      do_burst(32'h0000_4000, 8'd3, 3'd3, 64'hD0, 0, 1'b0, -1, 1, -1);
      // Missing RLAST at len=1, RLAST arrives on beat 3.
      do_burst(32'h0000_5000, 8'd1, 3'd3, 64'hE0, 0, 1'b0, -1, 3, -1);
      // Clean burst after errors.
      do_burst(32'h0000_6000, 8'd2, 3'd3, 64'hF0, 1, 1'b0, -1, 2, -1);
      // Reset during beat 2 of an 8-beat burst, then a fresh request.
      do_burst(32'h0000_7000, 8'd7, 3'd3, 64'h100, 0, 1'b0, -1, 7, 2);
      do_burst(32'h0000_8000, 8'd0, 3'd3, 64'h200, 0, 1'b0, -1, 0, -1);

      // Stall in DATA with no R traffic.
      req_valid = 1'b1;
      req_addr  = 32'h0000_9000;
      req_len   = 8'd0;
      req_size  = 3'd3;
      ar_q.push_back('{a: 32'h0000_9000, len: 8'd0, size: 3'd3});
      @(posedge clk); #1;
      req_valid   = 1'b0;
      axi.arready = 1'b1;
      @(posedge clk); #1;
      axi.arready = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("timeout_early", 64'(timeout), 64'd0);
`ifdef AXI_RD_TIMEOUT_EN
      begin
         int k = 0;
         while (!timeout && k < 40) begin
            @(posedge clk); #1;
            k++;
         end
         chk("timeout_fired", 64'(timeout), 64'd1);
         chk("timeout_err", 64'(err_sticky), 64'd1);
         chk("timeout_no_abort", 64'(busy), 64'd1);
      end
`else
      repeat (40) @(posedge clk);
      #1;
      chk("timeout_off", 64'(timeout), 64'd0);
      chk("stall_busy", 64'(busy), 64'd1);
`endif
      rstn = 1'b0;
      #1;
      chk("final_rst_busy", 64'(busy), 64'd0);
      chk("final_rst_timeout", 64'(timeout), 64'd0);
      @(posedge clk); #1;
      rstn = 1'b1;

      chk("exp_beats_drained", 64'(exp_q.size()), 64'd0);
      chk("exp_ar_drained", 64'(ar_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
